// File: rtl/bless_inject_ni.sv
// Network interface for a BLESS router injection port: queues whole packets from the
// local core and slices them into self-routable flits, with a loopback path for self-destined traffic.
module bless_inject_ni #(
  parameter int CURR_X        = 0,
  parameter int CURR_Y        = 0,
  parameter int DATA_WIDTH    = 32,
  parameter int FLITS_PER_PKT = 4,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  req_valid,
  output logic                                  req_ready,
  input  logic [2:0]                            req_dst_x,
  input  logic [2:0]                            req_dst_y,
  input  logic [FLITS_PER_PKT*DATA_WIDTH-1:0]   req_data,
  input  logic                                  inj_slot_free,
  output logic                                  flit_valid,
  output logic [DATA_WIDTH+18:0]                flit_out,
  output logic                                  loop_valid,
  input  logic                                  loop_ready,
  output logic [DATA_WIDTH+18:0]                loop_flit,
  output logic [15:0]                           stall_cnt
);

  localparam int FLIT_W  = DATA_WIDTH + 19;
  localparam int PAY_W   = FLITS_PER_PKT * DATA_WIDTH;
  localparam int ENTRY_W = PAY_W + 6;
  localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int SEL_W   = $clog2(FLITS_PER_PKT);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  logic [ENTRY_W-1:0]     mem [FIFO_DEPTH];
  logic [CNT_W-1:0]       count;
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [1:0]             seq;
  logic [3:0]             pkt_id;

  logic [ENTRY_W-1:0]     head;
  logic [2:0]             head_dx;
  logic [2:0]             head_dy;
  logic [PAY_W-1:0]       head_pay;
  logic [DATA_WIDTH-1:0]  words [FLITS_PER_PKT];
  logic [DATA_WIDTH-1:0]  cur_data;
  logic                   not_empty;
  logic                   is_local;
  logic                   tail;
  logic [FLIT_W-1:0]      flit;
  logic                   xfer;
  logic                   push;
  logic                   pop;

  // Queue status comes from registered state only, so a same-cycle pop never frees a slot.
  assign req_ready = (count != CNT_W'(FIFO_DEPTH));
  assign not_empty = (count != '0);
  assign push      = req_valid && req_ready;

  assign head     = mem[rd_ptr];
  assign head_dx  = head[ENTRY_W-1 -: 3];
  assign head_dy  = head[ENTRY_W-4 -: 3];
  assign head_pay = head[PAY_W-1:0];

  always_comb begin
    for (int i = 0; i < FLITS_PER_PKT; i++) begin
      words[i] = head_pay[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign cur_data = words[seq[SEL_W-1:0]];
  assign is_local = (head_dx == 3'(CURR_X)) && (head_dy == 3'(CURR_Y));
  assign tail     = (seq == 2'(FLITS_PER_PKT - 1));

  assign flit = {pkt_id, seq, tail, 3'(CURR_Y), 3'(CURR_X), head_dy, head_dx, cur_data};

  assign flit_valid = not_empty && !is_local;
  assign loop_valid = not_empty && is_local;

  // Idle outputs are forced to zero so stale queue contents never leak onto the ports.
  assign flit_out  = flit_valid ? flit : '0;
  assign loop_flit = loop_valid ? flit : '0;

  assign xfer = (flit_valid && inj_slot_free) || (loop_valid && loop_ready);
  assign pop  = xfer && tail;

  // Payload storage is not reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {req_dst_x, req_dst_y, req_data};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq    <= '0;
      pkt_id <= '0;
    end else if (xfer) begin
      if (tail) begin
        seq    <= '0;
        pkt_id <= pkt_id + 4'd1;
      end else begin
        seq    <= seq + 2'd1;
      end
    end
  end

  // Only network-side backpressure is counted; loopback waits are the core's own business.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (flit_valid && !inj_slot_free) begin
      stall_cnt <= sat_inc16(stall_cnt);
    end
  end

endmodule

// File: tb/tb_bless_inject_ni.sv
// Directed bench for bless_inject_ni at node (1,1): remote, starved, full-queue,
// loopback, pkt_id wrap and mid-packet reset scenarios.
module tb_bless_inject_ni;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid;
  logic         req_ready;
  logic [2:0]   req_dst_x;
  logic [2:0]   req_dst_y;
  logic [127:0] req_data;
  logic         inj_slot_free;
  logic         flit_valid;
  logic [50:0]  flit_out;
  logic         loop_valid;
  logic         loop_ready;
  logic [50:0]  loop_flit;
  logic [15:0]  stall_cnt;

  int n_checks = 0;
  int n_err    = 0;

  bless_inject_ni #(
    .CURR_X(1), .CURR_Y(1), .DATA_WIDTH(32), .FLITS_PER_PKT(4), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dst_x(req_dst_x), .req_dst_y(req_dst_y), .req_data(req_data),
    .inj_slot_free(inj_slot_free),
    .flit_valid(flit_valid), .flit_out(flit_out),
    .loop_valid(loop_valid), .loop_ready(loop_ready), .loop_flit(loop_flit),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [50:0] mk(input logic [3:0] pid, input int s, input int dx,
                                     input int dy, input logic [31:0] d);
    logic [1:0] sq;
    logic       tl;
    sq = 2'(s);
    tl = (s == 3);
    return {pid, sq, tl, 3'd1, 3'd1, 3'(dy), 3'(dx), d};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int dx, input int dy, input logic [31:0] base);
    req_dst_x = 3'(dx);
    req_dst_y = 3'(dy);
    for (int s = 0; s < 4; s++) req_data[s*32 +: 32] = base + 32'(s);
  endtask

  task automatic expect_flit(input string tag, input logic [3:0] pid, input int s,
                             input int dx, input int dy, input logic [31:0] base);
    check({tag, "_fv"}, flit_valid, 1'b1);
    check({tag, "_lv"}, loop_valid, 1'b0);
    check({tag, "_flit"}, flit_out, mk(pid, s, dx, dy, base + 32'(s)));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = 1'b0;
    inj_slot_free = 1'b0;
    loop_ready = 1'b0;
    step();
    step();
    #2;
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int pat [5] = '{1, 0, 1, 1, 1};
    int cur;
    rst_n = 1'b0;
    req_valid = 1'b0;
    inj_slot_free = 1'b0;
    loop_ready = 1'b0;
    set_req(0, 0, 32'h0);
    #2;
    check("rst_fv", flit_valid, 1'b0);
    check("rst_lv", loop_valid, 1'b0);
    check("rst_flit", flit_out, 51'd0);
    check("rst_loop", loop_flit, 51'd0);
    check("rst_rdy", req_ready, 1'b1);
    check("rst_stall", stall_cnt, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // single remote packet
    set_req(3, 2, 32'hA0);
    req_valid = 1'b1;
    inj_slot_free = 1'b1;
    check("t1_rdy0", req_ready, 1'b1);
    check("t1_idle", flit_valid, 1'b0);
    step();
    req_valid = 1'b0;
    for (int s = 0; s < 4; s++) begin
      expect_flit("t1", 4'd0, s, 3, 2, 32'hA0);
      check("t1_rdy", req_ready, 1'b1);
      step();
    end
    check("t1_done", flit_valid, 1'b0);
    check("t1_stall", stall_cnt, 16'd0);

    // slot starvation
    inj_slot_free = 1'b0;
    set_req(3, 2, 32'hA0);
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      expect_flit("t2_hold", 4'd1, 0, 3, 2, 32'hA0);
      step();
    end
    check("t2_stall", stall_cnt, 16'd5);
    inj_slot_free = 1'b1;
    for (int s = 0; s < 4; s++) begin
      expect_flit("t2", 4'd1, s, 3, 2, 32'hA0);
      step();
    end
    check("t2_done", flit_valid, 1'b0);
    check("t2_stall_end", stall_cnt, 16'd5);

    // queue full, no bubble between packets
    do_reset();
    req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_req(i + 2, 3 - i, 32'hC000_0000 + 32'(i << 8));
      check("t3_fill_rdy", req_ready, 1'(i < 4));
      step();
    end
    check("t3_stall", stall_cnt, 16'd4);
    inj_slot_free = 1'b1;
    for (int p = 0; p < 4; p++) begin
      for (int s = 0; s < 4; s++) begin
        expect_flit("t3", 4'(p), s, p + 2, 3 - p, 32'hC000_0000 + 32'(p << 8));
        check("t3_rdy", req_ready, 1'(p != 0));
        if (p == 1 && s == 0) req_valid = 1'b0;
        step();
      end
    end
    check("t3_drained", flit_valid, 1'b0);
    check("t3_no_loop", loop_valid, 1'b0);

    // loopback with toggling loop_ready
    inj_slot_free = 1'b0;
    set_req(1, 1, 32'hD0);
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    cur = 0;
    for (int k = 0; k < 5; k++) begin
      loop_ready = 1'(pat[k]);
      check("t4_lv", loop_valid, 1'b1);
      check("t4_fv", flit_valid, 1'b0);
      check("t4_fout", flit_out, 51'd0);
      check("t4_loop", loop_flit, mk(4'd4, cur, 1, 1, 32'hD0 + 32'(cur)));
      step();
      if (pat[k] != 0) cur++;
    end
    loop_ready = 1'b0;
    check("t4_done", loop_valid, 1'b0);
    check("t4_stall", stall_cnt, 16'd4);

    // pkt_id wrap and pointer wrap over 17 packets
    do_reset();
    inj_slot_free = 1'b1;
    for (int n = 0; n < 17; n++) begin
      set_req(n % 8, 2, 32'hE000_0000 + 32'(n << 8));
      req_valid = 1'b1;
      step();
      req_valid = 1'b0;
      for (int s = 0; s < 4; s++) begin
        expect_flit("t5", 4'(n), s, n % 8, 2, 32'hE000_0000 + 32'(n << 8));
        step();
      end
    end
    check("t5_done", flit_valid, 1'b0);

    // reset mid-packet with two packets queued
    inj_slot_free = 1'b0;
    set_req(2, 0, 32'hF0);
    req_valid = 1'b1;
    step();
    set_req(2, 0, 32'hF8);
    step();
    req_valid = 1'b0;
    inj_slot_free = 1'b1;
    expect_flit("t6_a", 4'd1, 0, 2, 0, 32'hF0);
    step();
    expect_flit("t6_a", 4'd1, 1, 2, 0, 32'hF0);
    step();
    rst_n = 1'b0;
    #1;
    check("t6_rst_fv", flit_valid, 1'b0);
    check("t6_rst_flit", flit_out, 51'd0);
    check("t6_rst_rdy", req_ready, 1'b1);
    check("t6_rst_stall", stall_cnt, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("t6_post_fv", flit_valid, 1'b0);
    check("t6_post_rdy", req_ready, 1'b1);
    set_req(4, 4, 32'h50);
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    expect_flit("t6_new", 4'd0, 0, 4, 4, 32'h50);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/bless_inject_ni.md
Name: bless_inject_ni

Overview:
- Local-port network interface feeding the router's injection port.
- Accepts packet requests from the local core and queues them.
- Slices each packet into independently routable BLESS flits, each stamped with destination, source, packet ID and sequence number.
- Injects a flit only in cycles when the router reports a free injection slot. Packets destined for this node bypass the network through a loopback port.

Parameters:
- CURR_X, 0, this node's X coordinate (3 bits).
- CURR_Y, 0, this node's Y coordinate (3 bits).
- DATA_WIDTH, 32, payload bits per flit.
- FLITS_PER_PKT, 4, flits per packet (power of 2, 2..4).
- FIFO_DEPTH, 4, packet queue entries (power of 2).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  core offers a packet.
- req_ready  out  1  queue can accept a packet.
- req_dst_x  in  3  destination X.
- req_dst_y  in  3  destination Y.
- req_data  in  FLITS_PER_PKT*DATA_WIDTH  payload; flit 0 is in the LSBs.
- inj_slot_free  in  1  router can take one injected flit this cycle.
- flit_valid  out  1  flit_out is valid for injection.
- flit_out  out  DATA_WIDTH+19  fields MSB→LSB:
  - pkt_id[3:0]
  - seq[1:0]
  - tail
  - src_y[2:0]
  - src_x[2:0]
  - dst_y[2:0]
  - dst_x[2:0]
  - data
- loop_valid  out  1  self-destined flit valid.
- loop_ready  in  1  local ejector accepts loop flit.
- loop_flit  out  DATA_WIDTH+19  same format as flit_out.
- stall_cnt  out  16  saturating count of injection stall cycles.

Behaviour:
- Reset values:
  - Queue count, read/write pointers, seq counter, pkt_id counter and stall_cnt all 0.
  - flit_valid and loop_valid are 0.
  - flit_out and loop_flit are 0.
  - req_ready is 1.
- Queue and request acceptance:
  - req_ready = (count != FIFO_DEPTH). It is computed from registered state only.
  - Push occurs on req_valid && req_ready; the entry stores {dst_x, dst_y, req_data}.
  - When full, a pop in the same cycle does not enable a push; req_ready stays 0 that cycle.
- Head packet classification:
  - local = (dst_x==CURR_X && dst_y==CURR_Y).
- Output valids:
  - flit_valid = (count!=0) && !local.
  - loop_valid = (count!=0) && local.
  - The two are mutually exclusive.
- Flit fields:
  - data = req_data slice [seq].
  - tail = (seq==FLITS_PER_PKT-1).
  - src = CURR.
  - pkt_id = current pkt_id counter.
  - Unused upper seq bits are 0.
- Transfer:
  - A network transfer occurs on flit_valid && inj_slot_free.
  - A loopback transfer occurs on loop_valid && loop_ready.
  - On a transfer with tail=0, seq increments.
  - On a transfer with tail=1:
    - seq clears to 0.
    - The head entry pops.
    - pkt_id increments, wrapping modulo 16.
- Stability: flit_out and loop_flit are combinational from registered state. They hold stable while valid and not transferred.
- Latency:
  - A request accepted in cycle N yields its first flit valid in cycle N+1 when the queue was empty.
  - Back-to-back packets have no bubble: the next head flit is valid in the cycle after the tail transfer.
- Stall counter:
  - stall_cnt increments each cycle with flit_valid && !inj_slot_free.
  - It saturates at 0xFFFF.
  - Loopback stalls are not counted.
- Push and pop in the same cycle (not full):
  - count is unchanged.
  - Both pointers advance, wrapping modulo FIFO_DEPTH.
- Empty queue: inj_slot_free and loop_ready are ignored; there is no state change.
- Reset asserted mid-packet:
  - All queued packets are discarded.
  - Outputs drop to 0 asynchronously.
  - pkt_id restarts at 0.
  - No partial-packet resume.
- Destination validity: out-of-mesh destinations are not checked and are injected as given.

Test Plan:
- Single remote packet: CURR=(1,1), dst=(3,2), data words 0xA0..0xA3, inj_slot_free=1.
  - flit_valid from N+1 to N+4.
  - seq 0..3; tail only on seq 3.
  - pkt_id 0; src=(1,1).
  - req_ready stays 1.
- Slot starvation: same packet with inj_slot_free=0 for 5 cycles, then 1.
  - flit 0 is held unchanged for 5 cycles.
  - stall_cnt=5.
  - Remaining flits then follow on consecutive cycles.
- Queue full: push 5 packets back-to-back with inj_slot_free=0.
  - Only 4 packets are accepted.
  - req_ready=0 after the 4th accept, including in a cycle where a tail pops.
  - pkt_ids emitted are 0,1,2,3 with no bubble between packets.
- Loopback: dst=(1,1) at CURR=(1,1).
  - loop_valid set and flit_valid=0.
  - loop_ready toggling 1,0,1,1,1 delivers 4 flits in 5 cycles.
  - stall_cnt is unchanged.
- Wrap-around: send 17 packets.
  - 17th packet carries pkt_id=0.
  - Pointers wrap with no data corruption.
- Reset mid-packet: assert rst_n=0 after seq 1 of packet 0 with 2 packets queued.
  - flit_valid=0 immediately.
  - After release: count=0, req_ready=1.
  - Next accepted packet emits pkt_id=0, seq=0.
